// File: rtl/core_mem_arbiter_pkg.sv
// Shared constants and types for the fetch/data memory-port arbiter.
package core_mem_arbiter_pkg;
  localparam int MEM_ADDR_W_DEF   = 64;
  localparam int MEM_DATA_W_DEF   = 64;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_CNT_W     = 4;

  // Bit positions inside the one-hot pick vector.
  localparam int PICK_I = 0;
  localparam int PICK_D = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DATA   = 2'd2
  } owner_e;
endpackage

// File: rtl/core_mem_arb_select.sv
// Priority select between fetch and data; data wins unless fetch has starved.
// Latency: combinational. Backpressure: none here, requesters hold req until gnt.
module core_mem_arb_select
  import core_mem_arbiter_pkg::*;
(
  input  logic       imem_req,
  input  logic       dmem_req,
  input  logic       starve_hit,
  output logic [1:0] pick
);

  always_comb begin
    pick = '0;
    if (dmem_req && !(imem_req && starve_hit)) begin
      pick[PICK_D] = 1'b1;
    end else if (imem_req) begin
      pick[PICK_I] = 1'b1;
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one memory port between fetch and load/store, locking the bus to the owner until gnt.
// Latency: zero cycles request and response. Backpressure: requester holds req/payload until its gnt.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int MEM_ADDR_W   = MEM_ADDR_W_DEF,
  parameter int MEM_DATA_W   = MEM_DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                    g_clk,
  input  logic                    g_reset,
  input  logic                    imem_req,
  input  logic [MEM_ADDR_W-1:0]   imem_addr,
  output logic                    imem_gnt,
  output logic                    imem_err,
  output logic [MEM_DATA_W-1:0]   imem_rdata,
  input  logic                    dmem_req,
  input  logic [MEM_ADDR_W-1:0]   dmem_addr,
  input  logic                    dmem_wen,
  input  logic [MEM_DATA_W/8-1:0] dmem_strb,
  input  logic [MEM_DATA_W-1:0]   dmem_wdata,
  output logic                    dmem_gnt,
  output logic                    dmem_err,
  output logic [MEM_DATA_W-1:0]   dmem_rdata,
  output logic                    mem_req,
  output logic [MEM_ADDR_W-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [MEM_DATA_W/8-1:0] mem_strb,
  output logic [MEM_DATA_W-1:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_err,
  input  logic [MEM_DATA_W-1:0]   mem_rdata
);

  owner_e                  owner_q, owner_d;
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [1:0]              pick;
  logic                    starve_hit;
  logic                    sel_i, sel_d;
  logic                    xfer_done;

  assign starve_hit = (starve_cnt_q == STARVE_CNT_W'(STARVE_LIMIT));

  core_mem_arb_select u_select (
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .starve_hit (starve_hit),
    .pick       (pick)
  );

  // Locked owners ignore the other side; dropping req while locked aborts the transfer.
  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    case (owner_q)
      IDLE: begin
        sel_i = pick[PICK_I];
        sel_d = pick[PICK_D];
      end
      IFETCH:  sel_i = imem_req;
      DATA:    sel_d = dmem_req;
      default: ;
    endcase
    if (g_reset) begin
      sel_i = 1'b0;
      sel_d = 1'b0;
    end
  end

  always_comb begin
    mem_req   = sel_i | sel_d;
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_strb  = '0;
    mem_wdata = '0;
    if (sel_d) begin
      mem_addr  = dmem_addr;
      mem_wen   = dmem_wen;
      mem_strb  = dmem_strb;
      mem_wdata = dmem_wdata;
    end else if (sel_i) begin
      mem_addr  = imem_addr;
    end
  end

  assign xfer_done  = mem_req & mem_gnt;
  assign imem_gnt   = sel_i & mem_gnt;
  assign imem_err   = sel_i & mem_gnt & mem_err;
  assign dmem_gnt   = sel_d & mem_gnt;
  assign dmem_err   = sel_d & mem_gnt & mem_err;
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

  always_comb begin
    owner_d      = IDLE;
    starve_cnt_d = starve_cnt_q;
    if (!xfer_done && sel_d) begin
      owner_d = DATA;
    end else if (!xfer_done && sel_i) begin
      owner_d = IFETCH;
    end
    if (xfer_done && sel_d && imem_req && !starve_hit) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end else if (xfer_done && sel_i) begin
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      owner_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // A response with no outstanding request means the bus slave is broken.
  mem_gnt_needs_req : assert property (@(posedge g_clk) disable iff (g_reset) mem_gnt |-> mem_req);

endmodule
